// File: rtl/types_pkg.sv
// Shared core types plus the fetch-path additions (PC type, reset vector, queue entry).
// Misaligned-redirect checking in fetch_unit is enabled by defining FETCH_MISALIGN_CHECK_EN.
package types_pkg;

    typedef logic [31:0] word_t;

    localparam int MEM_SIZE = 512;
    localparam int ADDR_W   = $clog2(MEM_SIZE);

    typedef logic [ADDR_W-1:0] address_t;

    typedef logic [31:0] pc_t;

    localparam pc_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        pc_t   pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched {pc, instr} entries with a single-cycle flush.
// The head entry is read straight out of storage so decode sees registered data only.
module fetch_queue
    import types_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t storage [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Flush beats push/pop; pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                storage[tail] <= wdata;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_entry = storage[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, imem address, fetch queue toward decode.
// Define FETCH_MISALIGN_CHECK_EN to halt fetch on a redirect to a non-word-aligned target.
module fetch_unit
    import types_pkg::*;
#(
    parameter pc_t RESET_PC = DEFAULT_RESET_PC,
    parameter int  QDEPTH   = 2
) (
    input  logic     clk,
    input  logic     rst,
    output address_t imem_addr,
    input  word_t    imem_instr,
    input  logic     redirect_valid,
    input  pc_t      redirect_pc,
    output logic     dec_valid,
    input  logic     dec_ready,
    output word_t    dec_instr,
    output pc_t      dec_pc,
    output logic     fetch_misaligned
);

    localparam int CW = $clog2(QDEPTH + 1);

    pc_t            fetch_pc;
    pc_t            redirect_target;
    logic [CW-1:0]  count;
    logic           halted;
    logic           push;
    logic           pop;
    fetch_entry_t   wdata;
    fetch_entry_t   head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    // A misaligned target is loaded as-is but parks fetch until reset.
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            halted <= 1'b1;
        end
    end

    assign fetch_misaligned = halted;
`else
    assign redirect_target  = redirect_pc & ~32'h0000_0003;
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    assign pop  = dec_valid & dec_ready;
    assign push = !redirect_valid & !halted & ((count < CW'(QDEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    assign wdata.pc    = fetch_pc;
    assign wdata.instr = imem_instr;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .wdata      (wdata),
        .head_entry (head_entry),
        .count      (count)
    );

    assign imem_addr = fetch_pc[ADDR_W+1:2];
    assign dec_valid = (count != '0);
    assign dec_instr = head_entry.instr;
    assign dec_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational instruction memory model.
// Expected values for the misaligned redirect follow FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;
    import types_pkg::*;

    logic     clk;
    logic     rst;
    address_t imem_addr;
    word_t    imem_instr;
    logic     redirect_valid;
    pc_t      redirect_pc;
    logic     dec_valid;
    logic     dec_ready;
    word_t    dec_instr;
    pc_t      dec_pc;
    logic     fetch_misaligned;

    word_t mem [MEM_SIZE];

    int checks;
    int errors;

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] rpc;
        bit          rdy;
        bit          chk;
        bit          chk_data;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic [31:0] ea;
        bit          em;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_instr       (imem_instr),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_instr        (dec_instr),
        .dec_pc           (dec_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
    endtask

    task automatic checkOutput(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, step, act, exp);
        end
    endtask

    task automatic checkRow(input int step, input vec_t v);
        checkOutput("dec_valid", step, {31'd0, dec_valid}, {31'd0, v.ev});
        checkOutput("imem_addr", step, {23'd0, imem_addr}, v.ea);
        checkOutput("fetch_misaligned", step, {31'd0, fetch_misaligned}, {31'd0, v.em});
        if (v.chk_data) begin
            checkOutput("dec_pc", step, dec_pc, v.epc);
            checkOutput("dec_instr", step, dec_instr, v.ei);
        end
    endtask

    // Rows: rst rv rpc rdy | chk chk_data ev epc ei ea em. Outputs are checked before the edge.
    task automatic addRow(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy, input bit chk, input bit cd, input bit ev, input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ea, input bit em);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.chk = chk; v.chk_data = cd; v.ev = ev;
        v.epc = epc; v.ei = ei; v.ea = ea; v.em = em;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] = 32'h100 + i;
        end

        // Streaming from reset with decode always ready.
        addRow(0, 0, 0,      1, 1, 1, 0, 32'h0,   32'h0,   0,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h0,   32'h100, 1,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h4,   32'h101, 2,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h8,   32'h102, 3,   0);
        // Mid-stream reset, then back-pressure for five cycles.
        addRow(1, 0, 0,      1, 0, 0, 0, 32'h0,   32'h0,   0,   0);
        addRow(0, 0, 0,      0, 1, 1, 0, 32'h0,   32'h0,   0,   0);
        addRow(0, 0, 0,      0, 1, 1, 1, 32'h0,   32'h100, 1,   0);
        addRow(0, 0, 0,      0, 1, 1, 1, 32'h0,   32'h100, 2,   0);
        addRow(0, 0, 0,      0, 1, 1, 1, 32'h0,   32'h100, 2,   0);
        addRow(0, 0, 0,      0, 1, 1, 1, 32'h0,   32'h100, 2,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h0,   32'h100, 2,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h4,   32'h101, 3,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h8,   32'h102, 4,   0);
        addRow(0, 0, 0,      0, 1, 1, 1, 32'hC,   32'h103, 5,   0);
        // Full queue redirected to 0x40.
        addRow(0, 1, 32'h40, 0, 1, 1, 1, 32'hC,   32'h103, 5,   0);
        addRow(0, 0, 0,      0, 1, 0, 0, 32'h0,   32'h0,   16,  0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h40,  32'h110, 17,  0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h44,  32'h111, 18,  0);
        // Redirect to 0x80 together with a pop of pc 0.
        addRow(1, 0, 0,      0, 0, 0, 0, 32'h0,   32'h0,   0,   0);
        addRow(0, 0, 0,      0, 1, 1, 0, 32'h0,   32'h0,   0,   0);
        addRow(0, 0, 0,      0, 1, 1, 1, 32'h0,   32'h100, 1,   0);
        addRow(0, 1, 32'h80, 1, 1, 1, 1, 32'h0,   32'h100, 2,   0);
        addRow(0, 0, 0,      1, 1, 0, 0, 32'h0,   32'h0,   32,  0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h80,  32'h120, 33,  0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h84,  32'h121, 34,  0);
        // Redirect to the last word; the address slice wraps to word 0.
        addRow(0, 1, 32'h7FC,1, 1, 1, 1, 32'h88,  32'h122, 35,  0);
        addRow(0, 0, 0,      1, 1, 0, 0, 32'h0,   32'h0,   511, 0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h7FC, 32'h2FF, 0,   0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h800, 32'h100, 1,   0);
        // Misaligned redirect to 0x42.
        addRow(0, 1, 32'h42, 1, 1, 1, 1, 32'h804, 32'h101, 2,   0);
`ifdef FETCH_MISALIGN_CHECK_EN
        addRow(0, 0, 0,      1, 1, 0, 0, 32'h0,   32'h0,   16,  1);
        addRow(0, 0, 0,      1, 1, 0, 0, 32'h0,   32'h0,   16,  1);
`else
        addRow(0, 0, 0,      1, 1, 0, 0, 32'h0,   32'h0,   16,  0);
        addRow(0, 0, 0,      1, 1, 1, 1, 32'h40,  32'h110, 17,  0);
`endif

        applyStimulus(1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            if (vecs[i].chk) begin
                checkRow(i, vecs[i]);
            end
            @(posedge clk);
            #1;
        end

        // Sticky behaviour after the misaligned redirect, then reset recovery.
        applyStimulus(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            checkOutput("halt_valid", 100 + k, {31'd0, dec_valid}, 32'd0);
            checkOutput("halt_flag", 100 + k, {31'd0, fetch_misaligned}, 32'd1);
`else
            checkOutput("resume_pc", 100 + k, dec_pc, 32'h44 + 4 * k);
            checkOutput("resume_valid", 100 + k, {31'd0, dec_valid}, 32'd1);
`endif
            @(posedge clk);
            #1;
        end

        applyStimulus(1, 0, 0, 1);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst_valid", 200, {31'd0, dec_valid}, 32'd0);
        checkOutput("post_rst_flag", 200, {31'd0, fetch_misaligned}, 32'd0);
        checkOutput("post_rst_pc", 200, dec_pc, 32'd0);
        checkOutput("post_rst_instr", 200, dec_instr, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_first_valid", 201, {31'd0, dec_valid}, 32'd1);
        checkOutput("post_rst_first_pc", 201, dec_pc, 32'd0);
        checkOutput("post_rst_first_instr", 201, dec_instr, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
